// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg_pkg
//  Description : Shared constants and types for the four-digit seven-segment
//                display controller: hex decode table, all-off patterns,
//                scan state enumeration and a leading-zero helper.
//  Revision    : 1.0  initial release
// ============================================================================
package seg_pkg;

   // Anode pattern with every digit disabled (active-low anodes)
   localparam logic [3:0] ANODE_OFF   = 4'b1111;

   // Segment pattern with every segment dark (active-low, bit0 = a .. bit6 = g)
   localparam logic [6:0] SEGMENT_OFF = 7'h7F;

   // Active-low hex glyphs, indexed by nibble value (element 15 listed first)
   localparam logic [15:0][6:0] HEX_SEG = {
      7'h0E,   // F
      7'h06,   // E
      7'h21,   // d
      7'h46,   // C
      7'h03,   // b
      7'h08,   // A
      7'h10,   // 9
      7'h00,   // 8
      7'h78,   // 7
      7'h02,   // 6
      7'h12,   // 5
      7'h19,   // 4
      7'h30,   // 3
      7'h24,   // 2
      7'h79,   // 1
      7'h40    // 0
   };

   // Scan sequencer states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      DRIVE = 2'd2
   } state_t;

   // True when every nibble from digit upward to digit 3 is zero.
   // Digit 0 always reports false so the rightmost digit is never suppressed.
   function automatic logic upper_nibbles_zero(input logic [15:0] value,
                                               input logic [1:0]  digit);
      logic zero;
      zero = 1'b0;
      case (digit)
         2'd1:    zero = (value[15:4]  == 12'h000);
         2'd2:    zero = (value[15:8]  == 8'h00);
         2'd3:    zero = (value[15:12] == 4'h0);
         default: zero = 1'b0;
      endcase
      return zero;
   endfunction

endpackage
`default_nettype wire

// File: rtl/hex_to_seg.sv
`default_nettype none
// ============================================================================
//  Module      : hex_to_seg
//  Description : Combinational hex nibble to active-low seven-segment decoder
//                with a blank override that turns every segment off.
//  Revision    : 1.0  initial release
// ============================================================================
module hex_to_seg
   import seg_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       blank,
   output logic [6:0] segment
);

   // Table lookup, forced dark when the digit is suppressed
   assign segment = blank ? SEGMENT_OFF : HEX_SEG[nibble];

endmodule
`default_nettype wire

// File: rtl/seven_seg_display_controller.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_display_controller
//  Description : Sequenced scanner for a four-digit common-anode display.
//                Each digit slot lasts PRESCALE cycles and opens with
//                BLANK_CYCLES of all-anodes-off to suppress ghosting. New
//                values arrive over valid/ready into a one-entry pending
//                register and are committed only at frame boundaries (or any
//                time while idle), so a frame never mixes two values.
//  Revision    : 1.0  initial release
// ============================================================================
module seven_seg_display_controller
   import seg_pkg::*;
#(
   parameter int PRESCALE     = 1000,
   parameter int BLANK_CYCLES = 16,
   parameter int LZ_BLANK     = 1
)
(
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   input  logic        load_valid,
   input  logic [15:0] load_data,
   input  logic [3:0]  load_dp,
   output logic        load_ready,
   output logic [3:0]  anode,
   output logic [6:0]  segment,
   output logic        dp,
   output logic        frame_done
);

   localparam int            PW         = $clog2(PRESCALE);
   localparam logic [PW-1:0] LAST_COUNT = PW'(PRESCALE - 1);
   localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYCLES);
   localparam logic [PW-1:0] SLOT_START = '0;
   localparam bit            LZ_EN      = (LZ_BLANK != 0);

   // Scan sequencer state
   state_t        state;
   logic [PW-1:0] prescaler;
   logic [1:0]    digit;

   // Value currently shown and the one-entry staging register behind it
   logic [15:0]   display_data;
   logic [3:0]    display_dp;
   logic [15:0]   pending_data;
   logic [3:0]    pending_dp;
   logic          pending_full;

   // Combinational helpers
   logic          tick;
   logic          last_digit;
   logic          commit;
   logic          accept;
   logic [PW-1:0] prescaler_next;
   logic [3:0]    cur_nibble;
   logic          digit_blank;
   logic [6:0]    digit_seg;

   // End of a digit slot; only meaningful while scanning
   assign tick       = (state != IDLE) && (prescaler == LAST_COUNT);
   assign last_digit = (digit == 2'd3);

   // Pending value moves to the display at a frame boundary, or at once when idle
   assign commit     = pending_full && ((tick && last_digit) || (state == IDLE));
   assign accept     = load_valid && !pending_full;
   assign load_ready = !pending_full;

   // Nibble for the digit being scanned, with leading-zero suppression
   assign cur_nibble  = display_data[{digit, 2'b00} +: 4];
   assign digit_blank = LZ_EN && upper_nibbles_zero(display_data, digit);

   hex_to_seg u_hex_to_seg (
      .nibble  (cur_nibble),
      .blank   (digit_blank),
      .segment (digit_seg)
   );

   // Next prescaler value: cleared while idle or disabled and at each slot end
   always_comb begin
      prescaler_next = '0;
      if (enable && (state != IDLE) && !tick) begin
         prescaler_next = prescaler + PW'(1);
      end
   end

   // Scan FSM, slot counters and registered pin drivers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         prescaler  <= '0;
         digit      <= 2'd0;
         anode      <= ANODE_OFF;
         segment    <= SEGMENT_OFF;
         dp         <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         prescaler  <= prescaler_next;
         frame_done <= enable && tick && last_digit;
         if (!enable) begin
            // Go dark immediately and restart from digit 0 on re-enable
            state   <= IDLE;
            digit   <= 2'd0;
            anode   <= ANODE_OFF;
            segment <= SEGMENT_OFF;
            dp      <= 1'b1;
         end else begin
            // State follows the position within the slot
            state <= (prescaler_next < BLANK_END) ? BLANK : DRIVE;

            if (state == IDLE) begin
               digit <= 2'd0;
            end else if (tick) begin
               digit <= digit + 2'd1;
            end

            anode <= (state == DRIVE) ? ~(4'b0001 << digit) : ANODE_OFF;

            // Cathodes change only at a slot start, while anodes are still off
            if ((state != IDLE) && (prescaler == SLOT_START)) begin
               segment <= digit_seg;
               dp      <= ~display_dp[digit];
            end
         end
      end
   end

   // Load handshake and frame-aligned commit of the pending value
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pending_data <= 16'h0000;
         pending_dp   <= 4'h0;
         pending_full <= 1'b0;
         display_data <= 16'h0000;
         display_dp   <= 4'h0;
      end else begin
         if (accept) begin
            pending_data <= load_data;
            pending_dp   <= load_dp;
            pending_full <= 1'b1;
         end else if (commit) begin
            pending_full <= 1'b0;
         end

         if (commit) begin
            display_data <= pending_data;
            display_dp   <= pending_dp;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_display_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seven_seg_display_controller
//  Description : Randomized self-checking bench for the seven-segment
//                controller. Expected pins are derived from the scan position
//                (cycles since scanning began) and a one-slot load buffer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seven_seg_display_controller;

   localparam int P      = 8;
   localparam int B      = 2;
   localparam int CYCLES = 4000;

   logic        clock = 1'b0;
   logic        reset;
   logic        enable;
   logic        load_valid;
   logic [15:0] load_data;
   logic [3:0]  load_dp;
   logic        load_ready;
   logic [3:0]  anode;
   logic [6:0]  segment;
   logic        dp;
   logic        frame_done;

   seven_seg_display_controller #(
      .PRESCALE     (P),
      .BLANK_CYCLES (B),
      .LZ_BLANK     (1)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_dp    (load_dp),
      .load_ready (load_ready),
      .anode      (anode),
      .segment    (segment),
      .dp         (dp),
      .frame_done (frame_done)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_pass   = 0;

   // Active-high gfedcba patterns of the standard hex glyphs
   logic [6:0] hi_tab [16];

   // Reference model state (values valid during the current cycle)
   bit          m_scan;
   int          m_pos;
   logic [15:0] m_disp;
   logic [3:0]  m_dpv;
   bit          m_pfull;
   logic [15:0] m_pdata;
   logic [3:0]  m_pdp;
   logic [3:0]  e_an;
   logic [6:0]  e_seg;
   logic        e_dp;
   logic        e_fd;
   bit          lv_pending;

   int  off_left;
   bit  forced_drop_done;
   bit  rst_done;
   int  dir_i;
   logic [15:0] dir_val [4] = '{16'h1234, 16'h0050, 16'h0000, 16'h8F0E};
   logic [3:0]  dir_dp  [4] = '{4'b0010, 4'b0000, 4'b0001, 4'b1111};
   int          dir_cyc [4] = '{1, 120, 300, 500};

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
   endtask

   function automatic logic [6:0] exp_seg(input logic [15:0] v, input int d);
      logic [15:0] upper;
      logic [3:0]  nib;
      upper = v >> (4 * d);
      nib   = upper[3:0];
      if (d > 0 && upper == 16'h0000) return 7'h7F;
      return ~hi_tab[nib];
   endfunction

   task automatic model_reset();
      m_scan = 0; m_pos = 0;
      m_disp = '0; m_dpv = '0;
      m_pfull = 0; m_pdata = '0; m_pdp = '0;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
      lv_pending = 0;
   endtask

   // Check this cycle's pins, choose next inputs, advance the model by one edge
   task automatic step(input int cyc);
      int   phase;
      int   dig;
      bit   acc;
      bit   boundary;
      int   k;
      logic [31:0] mask;

      check_eq("anode",      {12'h0, anode},      {12'h0, e_an});
      check_eq("segment",    {9'h0, segment},     {9'h0, e_seg});
      check_eq("dp",         {15'h0, dp},         {15'h0, e_dp});
      check_eq("frame_done", {15'h0, frame_done}, {15'h0, e_fd});
      check_eq("load_ready", {15'h0, load_ready}, {15'h0, !m_pfull});

      phase = m_pos % P;
      dig   = (m_pos / P) % 4;

      // enable: mostly on, with a directed drop during digit 2 drive and random drops
      if (off_left > 0) begin
         enable = 1'b0;
         off_left--;
      end else begin
         enable = 1'b1;
         if ((!forced_drop_done && cyc > 150 && m_scan && dig == 2 && phase == 5) ||
             ($urandom_range(0, 299) == 0)) begin
            enable = 1'b0;
            off_left = $urandom_range(0, 12);
            forced_drop_done = 1;
         end
      end

      // load offer: hold while stalled, otherwise directed or random
      if (!lv_pending) begin
         if (dir_i < 4 && cyc >= dir_cyc[dir_i]) begin
            load_valid = 1'b1;
            load_data  = dir_val[dir_i];
            load_dp    = dir_dp[dir_i];
            dir_i++;
         end else if ($urandom_range(0, 3) == 0) begin
            k          = $urandom_range(0, 4);
            mask       = (32'h1 << (4 * k)) - 32'h1;
            load_valid = 1'b1;
            load_data  = 16'($urandom & mask);
            load_dp    = 4'($urandom);
         end else begin
            load_valid = 1'b0;
         end
      end

      // Pins after the edge reflect the scan position of this cycle
      if (!enable) begin
         e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
      end else if (!m_scan) begin
         e_an = 4'hF; e_fd = 1'b0;
      end else begin
         e_an = (phase < B) ? 4'hF : (4'hF ^ (4'h1 << dig));
         if (phase == 0) begin
            e_seg = exp_seg(m_disp, dig);
            e_dp  = ~m_dpv[dig];
         end
         e_fd = (phase == P - 1) && (dig == 3);
      end

      boundary = m_scan && (phase == P - 1) && (dig == 3);
      acc      = load_valid && !m_pfull;
      if (m_pfull && (!m_scan || boundary)) begin
         m_disp  = m_pdata;
         m_dpv   = m_pdp;
         m_pfull = 0;
      end
      if (acc) begin
         m_pdata = load_data;
         m_pdp   = load_dp;
         m_pfull = 1;
      end
      lv_pending = load_valid && !acc;

      if (enable) begin
         m_pos  = m_scan ? m_pos + 1 : 0;
         m_scan = 1;
      end else begin
         m_scan = 0;
         m_pos  = 0;
      end
   endtask

   // Asynchronous reset mid-slot, away from any clock edge
   task automatic mid_slot_reset();
      #2 reset = 1'b1;
      #1;
      check_eq("async_rst_anode",   {12'h0, anode},      16'h000F);
      check_eq("async_rst_segment", {9'h0, segment},     16'h007F);
      check_eq("async_rst_dp",      {15'h0, dp},         16'h0001);
      check_eq("async_rst_ready",   {15'h0, load_ready}, 16'h0001);
      check_eq("async_rst_fdone",   {15'h0, frame_done}, 16'h0000);
      enable     = 1'b0;
      load_valid = 1'b0;
      off_left   = 0;
      @(posedge clock);
      #1;
      check_eq("rst_hold_anode", {12'h0, anode}, 16'h000F);
      @(negedge clock);
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      hi_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
      reset      = 1'b1;
      enable     = 1'b0;
      load_valid = 1'b0;
      load_data  = 16'h0000;
      load_dp    = 4'h0;
      off_left   = 0;
      forced_drop_done = 0;
      rst_done   = 0;
      dir_i      = 0;
      model_reset();

      #12;
      check_eq("rst_anode",   {12'h0, anode},      16'h000F);
      check_eq("rst_segment", {9'h0, segment},     16'h007F);
      check_eq("rst_dp",      {15'h0, dp},         16'h0001);
      check_eq("rst_ready",   {15'h0, load_ready}, 16'h0001);
      check_eq("rst_fdone",   {15'h0, frame_done}, 16'h0000);

      @(negedge clock);
      reset = 1'b0;
      model_reset();

      for (int cyc = 0; cyc < CYCLES; cyc++) begin
         if (!rst_done && cyc > 1500 && m_pfull && m_scan && (m_pos % P) == 4) begin
            rst_done = 1;
            mid_slot_reset();
         end
         step(cyc);
         @(negedge clock);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/seven_seg_display_controller.md
# seven_seg_display_controller

Sequences the four-digit, common-anode seven-segment display. It time-multiplexes a 16-bit hex value across the digits using an internal prescaler and a per-digit blanking interval to suppress ghosting. It accepts new values through a valid/ready handshake and applies them only at frame boundaries, so a frame never shows mixed values. It sits between system logic and the board anode/cathode pins, replacing the free-running scanner with a sequenced controller.

## Interface
- PRESCALE, 1000: clock cycles per digit slot; must be ≥ 2.
- BLANK_CYCLES, 16: cycles at the start of each slot with all anodes off; 0 ≤ BLANK_CYCLES < PRESCALE.
- LZ_BLANK, 1: 1 = suppress leading zeros on digits 3..1.

- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- enable  in  1  0 = display dark and scan held.
- load_valid  in  1  new value offered.
- load_data  in  16  hex value; nibble i drives digit i (0 = R, 3 = L).
- load_dp  in  4  decimal point per digit, 1 = on.
- load_ready  out  1  pending slot empty.
- anode  out  4  active-low digit enables.
- segment  out  7  active-low, bit0 = a … bit6 = g.
- dp  out  1  active-low decimal point.
- frame_done  out  1  one-cycle pulse at end of digit-3 slot.

## Operation
- **Reset values:**
  - anode = 4'b1111, segment = 7'h7F, dp = 1.
  - load_ready = 1, frame_done = 0.
  - digit = 0, prescaler = 0, display and pending registers = 0, state = IDLE.
- **States:**
  - IDLE: enable = 0; outputs dark; prescaler and digit held at 0.
  - BLANK: prescaler < BLANK_CYCLES; anodes all 1.
  - DRIVE: remaining cycles of the slot; anode[digit] = 0.
- **Transitions:**
  - IDLE→BLANK when enable = 1.
  - BLANK→DRIVE when prescaler reaches BLANK_CYCLES.
  - DRIVE→BLANK on tick (prescaler = PRESCALE-1). On the tick, prescaler→0 and digit→digit+1 mod 4.
  - Any state→IDLE the cycle after enable = 0.
- **Handshake:**
  - Transfer occurs on load_valid & load_ready. load_data and load_dp are captured into the pending register and pending_full is set.
  - load_ready = ~pending_full.
- **Commit:**
  - Occurs on a tick with digit = 3, or on any cycle in IDLE, when pending_full = 1.
  - pending is copied to display and pending_full clears.
- **Simultaneous accept and commit, pending empty:** the accepted value goes to pending and commits at the following boundary.
- **Leading-zero blanking:** digit i (i ≥ 1) shows segment = 7'h7F when LZ_BLANK = 1 and nibbles 3..i are all zero. Digit 0 is never blanked. dp is unaffected.
- **Decode:** standard hex 0–F: 0 = 7'h40, 1 = 7'h79, 8 = 7'h00, F = 7'h0E (active-low, g..a).

## Timing
- All outputs are registered, one cycle after the state and counter they reflect.
- Slot length is PRESCALE cycles. Frame length is 4·PRESCALE.
- anode is low for PRESCALE-BLANK_CYCLES cycles per slot.
- segment and dp update at the first BLANK cycle of each slot, never while an anode is low.
- frame_done is asserted in the cycle after the digit-3 tick, coincident with the digit-0 BLANK start.
- Accept-to-display latency is at most 4·PRESCALE+2 cycles while enabled.
- Reset mid-slot: everything returns to reset values immediately (asynchronous), and the pending value is lost.
- enable deasserted mid-DRIVE: anodes go dark the next cycle. On re-enable, scanning restarts at digit 0, BLANK.

## Structure
- Shared package `seg_pkg`:
  - the hex-to-segment constant array;
  - anode and segment all-off constants;
  - the state enum (IDLE, BLANK, DRIVE).
- Sub-module `hex_to_seg` (combinational 4→7 decoder with blank input), instantiated once on the muxed nibble.
- The digit counter may reuse the existing `dff` cells or behavioral registers.

## Test plan
(PRESCALE = 8, BLANK_CYCLES = 2 unless noted.)
- **Reset then enable:** reset → anode = 1111, segment = 7F, load_ready = 1. After enable, anode = 1110 for cycles 3–8 of slot 0, then 1111 for 2 cycles, then 1101.
- **Load 16'h1234 with dp = 4'b0010:** digit 0 shows 7'h19 (4); digit 1 shows 7'h30 (3) with dp = 0; digit 3 shows 7'h79 (1). Display changes only after frame_done.
- **Two back-to-back loads:** load_ready drops after the first accept. The second load_valid stalls until the commit, then is accepted.
- **LZ_BLANK, value 16'h0050:** digits 3 and 2 segment = 7F; digit 1 = 7'h12; digit 0 = 7'h40. Value 16'h0000 → only digit 0 lit (7'h40).
- **enable dropped mid-DRIVE of digit 2:** dark next cycle. A pending value commits in IDLE. Re-enable → scan resumes at digit 0 with the new value.
- **Asynchronous reset asserted mid-slot with pending full:** outputs go to reset values without a clock edge; load_ready = 1 and display = 0 after release.
